// File: rtl/adder_pkg.sv
// adder_pkg: register word offsets and response codes for the adder slave
package adder_pkg;
    localparam logic [1:0] ADDR_OP_A   = 2'd0;
    localparam logic [1:0] ADDR_OP_B   = 2'd1;
    localparam logic [1:0] ADDR_SUM    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;
endpackage

// File: rtl/adder_core.sv
// adder_core: combinational operand sum with carry-out
module adder_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry
);
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/adder.sv
// adder: AXI4-Lite-style slave with two operand registers, exposing their sum and carry
module adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic                    s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_op_a, r_op_b, w_sum, w_rd_data;
    logic [1:0]            w_wr_idx, w_rd_idx;
    logic                  w_carry, w_wr_go, w_wr_acc, w_wr_bad, w_rd_go, w_rd_acc, w_rd_unm;
    logic                  w_unused;

    adder_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .o_sum  (w_sum),
        .o_carry(w_carry)
    );

    assign w_unused = &{1'b0, s1_axi_awaddr[1:0], s1_axi_araddr[1:0], s1_axi_wstrb[NB]};

    always_comb begin
        w_wr_go   = s1_axi_awvalid & s1_axi_wvalid & ~s1_axi_awready & ~s1_axi_bvalid;
        w_wr_acc  = s1_axi_awready & s1_axi_wready & s1_axi_awvalid & s1_axi_wvalid;
        w_wr_idx  = s1_axi_awaddr[3:2];
        w_wr_bad  = (|s1_axi_awaddr[ADDR_WIDTH-1:4]) | (w_wr_idx != ADDR_OP_A && w_wr_idx != ADDR_OP_B);
        w_rd_go   = s1_axi_arvalid & ~s1_axi_arready & ~s1_axi_rvalid;
        w_rd_acc  = s1_axi_arready & s1_axi_arvalid;
        w_rd_idx  = s1_axi_araddr[3:2];
        w_rd_unm  = |s1_axi_araddr[ADDR_WIDTH-1:4];
        w_rd_data = w_rd_unm                ? '0 :
                    w_rd_idx == ADDR_OP_A   ? r_op_a :
                    w_rd_idx == ADDR_OP_B   ? r_op_b :
                    w_rd_idx == ADDR_SUM    ? w_sum :
                                              {{(DATA_WIDTH-1){1'b0}}, w_carry};
    end

    // Only enabled byte lanes of a mapped operand register change
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_wr_acc && !w_wr_bad) begin
            for (int i = 0; i < NB; i++) begin
                if (s1_axi_wstrb[i] && w_wr_idx == ADDR_OP_A) r_op_a[i*8 +: 8] <= s1_axi_wdata[i*8 +: 8];
                if (s1_axi_wstrb[i] && w_wr_idx == ADDR_OP_B) r_op_b[i*8 +: 8] <= s1_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_awready <= 1'b0;
            s1_axi_wready  <= 1'b0;
            s1_axi_bvalid  <= 1'b0;
            s1_axi_bresp   <= RESP_OKAY;
        end else begin
            s1_axi_awready <= w_wr_go;
            s1_axi_wready  <= w_wr_go;
            if (w_wr_acc) begin
                s1_axi_bvalid <= 1'b1;
                s1_axi_bresp  <= w_wr_bad ? RESP_SLVERR : RESP_OKAY;
            end else if (s1_axi_bready) begin
                s1_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured from pre-edge register values, so a same-cycle write is not visible
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            s1_axi_arready <= 1'b0;
            s1_axi_rvalid  <= 1'b0;
            s1_axi_rdata   <= '0;
            s1_axi_rresp   <= RESP_OKAY;
        end else begin
            s1_axi_arready <= w_rd_go;
            if (w_rd_acc) begin
                s1_axi_rvalid <= 1'b1;
                s1_axi_rdata  <= w_rd_data;
                s1_axi_rresp  <= w_rd_unm ? RESP_SLVERR : RESP_OKAY;
            end else if (s1_axi_rready) begin
                s1_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for the adder slave; expected responses are queued at issue and checked on return
module tb_adder;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [4:0]  wstrb = '0;
    logic        awready, wready, bresp, bvalid, arready, rresp, rvalid;
    logic [31:0] rdata;
    logic        wr_q[$];
    logic [32:0] rd_q[$];
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    adder dut (
        .s1_axi_aclk(clk), .s1_axi_aresetn(aresetn),
        .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
        .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
        .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
        .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
        .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic exp_resp, input int hold);
        logic exp;
        bit   ok;
        wr_q.push_back(exp_resp);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = {1'b1, s}; awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = awready & wready;
        end
        if (!ok) check("wr_accept_timeout", 0, 1);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = bvalid;
        end
        if (!ok) check("bvalid_timeout", 0, 1);
        exp = wr_q.pop_front();
        check("bresp", bresp, exp);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp);
            check("awready_hold", awready, 0);
        end
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_r, input int hold);
        logic [32:0] exp;
        bit          ok;
        rd_q.push_back({exp_r, exp_d});
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) check("ar_accept_timeout", 0, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rvalid;
        end
        if (!ok) check("rvalid_timeout", 0, 1);
        exp = rd_q.pop_front();
        check($sformatf("rd@%0h", a), {rresp, rdata}, exp);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", {rresp, rdata}, exp);
            check("arready_hold", arready, 0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk) aresetn = 1'b1;

        axi_write(8'h00, 32'h0000AABB, 4'hF, 1'b0, 0);
        axi_write(8'h04, 32'h0000CCDD, 4'hF, 1'b0, 0);
        axi_read(8'h08, 32'h00017798, 1'b0, 0);
        axi_read(8'h0C, 32'h0, 1'b0, 0);

        axi_write(8'h00, 32'hFFFFFFFF, 4'hF, 1'b0, 0);
        axi_write(8'h04, 32'h00000001, 4'hF, 1'b0, 0);
        axi_read(8'h08, 32'h0, 1'b0, 0);
        axi_read(8'h0E, 32'h1, 1'b0, 0);

        axi_write(8'h00, 32'h0, 4'hF, 1'b0, 0);
        axi_write(8'h00, 32'h12345678, 4'h1, 1'b0, 0);
        axi_read(8'h00, 32'h00000078, 1'b0, 0);
        axi_write(8'h00, 32'h12345678, 4'hC, 1'b0, 0);
        axi_read(8'h00, 32'h12340078, 1'b0, 0);

        axi_write(8'h08, 32'hDEADBEEF, 4'hF, 1'b1, 0);
        axi_write(8'h20, 32'hDEADBEEF, 4'hF, 1'b1, 0);
        axi_read(8'h08, 32'h12340079, 1'b0, 0);
        axi_read(8'h10, 32'h0, 1'b1, 0);

        axi_write(8'h04, 32'h00000005, 4'hF, 1'b0, 3);
        axi_read(8'h04, 32'h00000005, 1'b0, 3);

        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h0000FFFF; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) check("rst_wr_accept_timeout", 0, 1);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", bvalid, 1);
        #1 aresetn = 1'b0;
        #1 check("async_rst_bvalid", bvalid, 0);
        @(negedge clk) aresetn = 1'b1;
        axi_read(8'h00, 32'h0, 1'b0, 0);
        axi_read(8'h04, 32'h0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
